swo_uart_rx: RTL

SWO_UART_RX -- requirements
Module: swo_uart_rx

---
 rtl/swo_uart_rx_pkg.sv | 39 +++
 rtl/swo_sync2.sv | 28 ++
 rtl/swo_uart_rx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/swo_uart_rx_pkg.sv
// Shared definitions for the SWO UART receiver: FSM state encoding, data-bit
// clamp limits, synchronizer reset level and character alignment helpers.
package swo_uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_t;

   localparam logic [3:0] DATA_BITS_MIN    = 4'd5;
   localparam logic [3:0] DATA_BITS_MAX    = 4'd8;
   localparam logic       SYNC_RESET_VALUE = 1'b1;

   // Out-of-range character lengths saturate to the nearest supported size.
   function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits);
      logic [3:0] clamped;
      if (bits < DATA_BITS_MIN) begin
         clamped = DATA_BITS_MIN;
      end else if (bits > DATA_BITS_MAX) begin
         clamped = DATA_BITS_MAX;
      end else begin
         clamped = bits;
      end
      return clamped;
   endfunction

   // Bits enter at the MSB, so a short character sits in the top bits and must
   // be moved down; the logical shift leaves the unused upper bits at zero.
   function automatic logic [7:0] right_align(input logic [7:0] shreg,
                                              input logic [3:0] bits);
      logic [3:0] amount;
      amount = DATA_BITS_MAX - bits;
      return shreg >> amount;
   endfunction

endpackage

// File: rtl/swo_sync2.sv
// Two-flop synchronizer for the asynchronous SWO line; both flops reset to the
// idle-high level so no false start edge is seen when reset is released.
module swo_sync2
   import swo_uart_rx_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;
   logic stable;

   // Metastability filter: two back-to-back flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= SYNC_RESET_VALUE;
         stable <= SYNC_RESET_VALUE;
      end else begin
         meta   <= d;
         stable <= meta;
      end
   end

   assign q = stable;

endmodule

// File: rtl/swo_uart_rx.sv
// UART (NRZ) receiver for the SWO trace pin: mid-bit sampling with a
// configurable divider, 5..8 data bits, 1 or 2 stop bits, framing detection.
module swo_uart_rx #(
   parameter int pDIV_WIDTH = 8
) (
   input  logic                  trace_clk,
   input  logic                  reset_i,
   input  logic                  I_swo,
   input  logic                  I_enable,
   input  logic [pDIV_WIDTH-1:0] I_bitrate_div,
   input  logic [1:0]            I_stop_bits,
   input  logic [3:0]            I_data_bits,
   output logic [7:0]            O_data,
   output logic                  O_data_valid,
   output logic                  O_framing_error,
   output logic                  O_busy
);

   import swo_uart_rx_pkg::*;

   localparam logic [pDIV_WIDTH-1:0] DIV_ONE = pDIV_WIDTH'(1'b1);

   logic                  rx_s;
   logic                  rx_prev;
   rx_state_t             state;
   rx_state_t             state_next;
   logic [pDIV_WIDTH-1:0] cnt;
   logic [pDIV_WIDTH-1:0] cnt_next;
   logic [pDIV_WIDTH-1:0] div_lat;
   logic [pDIV_WIDTH-1:0] div_next;
   logic [pDIV_WIDTH-1:0] div_eff;
   logic [3:0]            nbits_lat;
   logic [3:0]            nbits_next;
   logic                  two_stop_lat;
   logic                  two_stop_next;
   logic [2:0]            bit_idx;
   logic [2:0]            bit_idx_next;
   logic                  stop_left;
   logic                  stop_left_next;
   logic [7:0]            shreg;
   logic [7:0]            shreg_next;
   logic [7:0]            data_r;
   logic [7:0]            data_next;
   logic                  valid_r;
   logic                  valid_next;
   logic                  err_r;
   logic                  err_next;
   logic                  busy_r;
   logic                  sample;
   logic                  last_data_bit;

   swo_sync2 u_sync (
      .clk (trace_clk),
      .rst (reset_i),
      .d   (I_swo),
      .q   (rx_s)
   );

   // Divider of zero would give no time between samples; run it as one.
   always_comb begin
      div_eff       = (I_bitrate_div == '0) ? DIV_ONE : I_bitrate_div;
      sample        = (cnt == '0);
      last_data_bit = ({1'b0, bit_idx} == (nbits_lat - 4'd1));
   end

   // Next-state and datapath decode; every target defaults to holding.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      div_next       = div_lat;
      nbits_next     = nbits_lat;
      two_stop_next  = two_stop_lat;
      bit_idx_next   = bit_idx;
      stop_left_next = stop_left;
      shreg_next     = shreg;
      data_next      = data_r;
      valid_next     = 1'b0;
      err_next       = 1'b0;

      if (!I_enable) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               // Frame configuration is frozen here for the whole character.
               if (rx_prev && !rx_s) begin
                  state_next    = START;
                  cnt_next      = div_eff >> 1;
                  div_next      = div_eff;
                  nbits_next    = clamp_data_bits(I_data_bits);
                  two_stop_next = (I_stop_bits >= 2'd2);
               end else begin
                  state_next = IDLE;
               end
            end

            START: begin
               if (sample) begin
                  cnt_next = div_lat;
                  if (!rx_s) begin
                     state_next   = DATA;
                     bit_idx_next = 3'd0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  cnt_next = cnt - DIV_ONE;
               end
            end

            DATA: begin
               if (sample) begin
                  cnt_next   = div_lat;
                  shreg_next = {rx_s, shreg[7:1]};
                  if (last_data_bit) begin
                     state_next     = STOP;
                     stop_left_next = two_stop_lat;
                  end else begin
                     bit_idx_next = bit_idx + 3'd1;
                  end
               end else begin
                  cnt_next = cnt - DIV_ONE;
               end
            end

            STOP: begin
               if (sample) begin
                  cnt_next = div_lat;
                  if (!rx_s) begin
                     state_next = WAIT_HIGH;
                     err_next   = 1'b1;
                  end else if (stop_left) begin
                     stop_left_next = 1'b0;
                  end else begin
                     state_next = IDLE;
                     data_next  = right_align(shreg, nbits_lat);
                     valid_next = 1'b1;
                  end
               end else begin
                  cnt_next = cnt - DIV_ONE;
               end
            end

            // A held-low line (break) reports once, then waits for idle.
            WAIT_HIGH: begin
               if (rx_s) begin
                  state_next = IDLE;
               end else begin
                  state_next = WAIT_HIGH;
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge trace_clk) begin
      if (reset_i) begin
         state        <= IDLE;
         rx_prev      <= SYNC_RESET_VALUE;
         cnt          <= '0;
         div_lat      <= '0;
         nbits_lat    <= DATA_BITS_MAX;
         two_stop_lat <= 1'b0;
         bit_idx      <= 3'd0;
         stop_left    <= 1'b0;
         shreg        <= 8'h00;
         data_r       <= 8'h00;
         valid_r      <= 1'b0;
         err_r        <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state        <= state_next;
         rx_prev      <= rx_s;
         cnt          <= cnt_next;
         div_lat      <= div_next;
         nbits_lat    <= nbits_next;
         two_stop_lat <= two_stop_next;
         bit_idx      <= bit_idx_next;
         stop_left    <= stop_left_next;
         shreg        <= shreg_next;
         data_r       <= data_next;
         valid_r      <= valid_next;
         err_r        <= err_next;
         busy_r       <= (state_next != IDLE);
      end
   end

   assign O_data          = data_r;
   assign O_data_valid    = valid_r;
   assign O_framing_error = err_r;
   assign O_busy          = busy_r;

endmodule
